// File: rtl/simple_bus_mem_slave.sv
// simple_bus_mem_slave: byte-wide memory target for the simple_bus master.
// Grants the bus on req, accepts one single or 4-beat wrapping burst per
// start strobe, inserts WAIT_STATES idle cycles before the first beat and
// answers out-of-range addresses with a single error beat. Every output is
// a flop loaded from the next-state decode.
module simple_bus_mem_slave #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  output logic       gnt,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [1:0] mode,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       rdy,
  output logic       err
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANTED = 3'd1,
    S_WAIT    = 3'd2,
    S_BEAT    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic       wr_q, wr_d;
  logic [1:0] beats_q, beats_d;
  logic       gnt_d, rdy_d, err_d, oe_d;
  logic [7:0] mem [DEPTH];

  logic accept;
  logic oob;

  assign accept = (state_q == S_GRANTED) && req && start;
  assign oob    = ({1'b0, addr} >= DEPTH_LIM);

  // State register and transaction context (address, direction, counters)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      beats_q <= beats_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_GRANTED;
      end
      S_GRANTED: begin
        if (!req)          state_d = S_IDLE;
        else if (start) begin
          if (oob)                    state_d = S_ERR;
          else if (WAIT_STATES == 0)  state_d = S_BEAT;
          else                        state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) state_d = S_BEAT;
      end
      S_BEAT: begin
        if (beats_q == 2'd0) state_d = req ? S_GRANTED : S_IDLE;
      end
      S_ERR: begin
        state_d = req ? S_GRANTED : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction context update: capture on start, count waits, wrap burst address
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    beats_d = beats_q;
    if (accept) begin
      addr_d  = addr;
      wr_d    = mode[0];
      cnt_d   = WAIT_INIT;
      beats_d = mode[1] ? 2'd3 : 2'd0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end else if ((state_q == S_BEAT) && (beats_q != 2'd0)) begin
      addr_d  = {addr_q[7:2], addr_q[1:0] + 2'd1};
      beats_d = beats_q - 2'd1;
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    gnt_d = (state_d != S_IDLE);
    rdy_d = (state_d == S_BEAT) || (state_d == S_ERR);
    err_d = (state_d == S_ERR);
    oe_d  = (state_d == S_BEAT) && !wr_d;
  end

  // Registered bus outputs; data_out only reloads on read beats and holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= 1'b0;
      rdy      <= 1'b0;
      err      <= 1'b0;
      data_oe  <= 1'b0;
      data_out <= 8'h00;
    end else begin
      gnt     <= gnt_d;
      rdy     <= rdy_d;
      err     <= err_d;
      data_oe <= oe_d;
      if (oe_d) data_out <= mem[addr_d[AW-1:0]];
    end
  end

  // Byte store: cleared by reset, written at the edge that closes a write beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if ((state_q == S_BEAT) && wr_q) begin
      mem[addr_q[AW-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_simple_bus_mem_slave.sv
// Bench for simple_bus_mem_slave: table vectors, hand sequences for wait
// states / req drop / async reset, and random transactions against a byte
// array reference model.
module tb_simple_bus_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req, start, gnt, data_oe, rdy, err;
  logic [7:0] addr, data_in, data_out;
  logic [1:0] mode;

  logic       req_b, start_b, gnt_b, data_oe_b, rdy_b, err_b;
  logic [7:0] addr_b, data_in_b, data_out_b;
  logic [1:0] mode_b;

  simple_bus_mem_slave #(.DEPTH(16), .WAIT_STATES(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .start(start),
    .addr(addr), .mode(mode), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .rdy(rdy), .err(err)
  );

  simple_bus_mem_slave #(.DEPTH(16), .WAIT_STATES(3)) dut_ws (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .start(start_b),
    .addr(addr_b), .mode(mode_b), .data_in(data_in_b), .data_out(data_out_b),
    .data_oe(data_oe_b), .rdy(rdy_b), .err(err_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mm [16];
  logic [7:0] exp_dout;

  typedef struct {
    logic [1:0]  m;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        e;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference read: beat b of a transaction at a reads byte (a aligned to 4) + ((a+b) mod 4)
  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] r;
    int idx;
    r = '0;
    if (a < 8'd16) begin
      for (int b = 0; b < 4; b++) begin
        idx = (int'(a) / 4) * 4 + ((int'(a) + b) % 4);
        r[8*b +: 8] = mm[idx];
      end
    end
    return r;
  endfunction

  task automatic model_apply(input logic [1:0] m, input logic [7:0] a, input logic [31:0] wd);
    int idx;
    if (a < 8'd16 && m[0]) begin
      for (int b = 0; b < (m[1] ? 4 : 1); b++) begin
        idx = (int'(a) / 4) * 4 + ((int'(a) + b) % 4);
        mm[idx] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mm[i] = 8'h00;
    exp_dout = 8'h00;
  endtask

  task automatic regrant();
    req = 1'b1;
    @(negedge clk);
    check("regrant_gnt", gnt, 1);
  endtask

  // One transaction on the zero-wait DUT, entered at a negedge with gnt=1
  task automatic txn(input logic [1:0] m, input logic [7:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic e, input bit drop);
    int  nb;
    logic rd_beat;
    nb = e ? 1 : (m[1] ? 4 : 1);
    rd_beat = !e && !m[0];
    check("gnt_before_start", gnt, 1);
    start = 1'b1; mode = m; addr = a;
    @(negedge clk);
    start = 1'b0; addr = 8'($urandom); mode = 2'($urandom);
    for (int b = 0; b < nb; b++) begin
      check("beat_rdy", rdy, 1);
      check("beat_err", err, e);
      check("beat_gnt", gnt, 1);
      check("beat_data_oe", data_oe, rd_beat);
      if (rd_beat) exp_dout = rd[8*b +: 8];
      check("beat_data_out", data_out, exp_dout);
      data_in = wd[8*b +: 8];
      if (drop && b == 0) req = 1'b0;
      @(negedge clk);
    end
    check("after_rdy", rdy, 0);
    check("after_err", err, 0);
    check("after_data_oe", data_oe, 0);
    check("after_data_out_hold", data_out, exp_dout);
    if (drop) begin
      check("drop_gnt_low", gnt, 0);
      start = 1'b1;
      repeat (2) begin
        @(negedge clk);
        check("nognt_start_rdy", rdy, 0);
        check("nognt_gnt", gnt, 0);
      end
      start = 1'b0;
    end else begin
      check("after_gnt_held", gnt, 1);
    end
  endtask

  initial begin
    logic [1:0]  m;
    logic [7:0]  a;
    logic [31:0] wd;
    logic        e;
    bit          drop;

    rst_n = 1'b0; req = 1'b0; start = 1'b0; addr = '0; mode = '0; data_in = '0;
    req_b = 1'b0; start_b = 1'b0; addr_b = '0; mode_b = '0; data_in_b = '0;
    model_clear();

    vecs[0] = '{2'b01, 8'h03, 32'h0000_00A5, 32'h0,          1'b0};
    vecs[1] = '{2'b00, 8'h03, 32'h0,          32'h0000_00A5, 1'b0};
    vecs[2] = '{2'b11, 8'h06, 32'h4433_2211, 32'h0,          1'b0};
    vecs[3] = '{2'b10, 8'h04, 32'h0,          32'h2211_4433, 1'b0};
    vecs[4] = '{2'b11, 8'h10, 32'hDEAD_BEEF, 32'h0,          1'b1};
    vecs[5] = '{2'b00, 8'h10, 32'h0,          32'h0,          1'b1};
    vecs[6] = '{2'b10, 8'h07, 32'h0,          32'h1144_3322, 1'b0};
    vecs[7] = '{2'b00, 8'h0F, 32'h0,          32'h0,          1'b0};

    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_rdy", rdy, 0);
    check("rst_err", err, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_data_out", data_out, 8'h00);
    rst_n = 1'b1;
    regrant();

    // Table vectors: single write/read, wrapping bursts, out-of-range error
    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].m, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].e, 1'b0);
      model_apply(vecs[i].m, vecs[i].a, vecs[i].wd);
    end

    // Full readback: the rejected burst write must have left memory untouched
    for (int i = 0; i < 16; i++) txn(2'b00, 8'(i), 32'h0, model_read(8'(i)), 1'b0, 1'b0);

    // Burst read with req released after the first beat
    txn(2'b10, 8'h04, 32'h0, model_read(8'h04), 1'b0, 1'b1);
    regrant();

    // Wait-state instance: write then read, rdy only WAIT_STATES cycles later
    req_b = 1'b1;
    @(negedge clk);
    check("ws_gnt", gnt_b, 1);
    for (int k = 0; k < 2; k++) begin
      start_b = 1'b1; mode_b = (k == 0) ? 2'b01 : 2'b00; addr_b = 8'h02; data_in_b = 8'h7E;
      @(negedge clk);
      start_b = 1'b0;
      repeat (3) begin
        check("ws_wait_rdy", rdy_b, 0);
        check("ws_wait_gnt", gnt_b, 1);
        @(negedge clk);
      end
      check("ws_beat_rdy", rdy_b, 1);
      check("ws_beat_err", err_b, 0);
      check("ws_beat_oe", data_oe_b, (k == 1));
      if (k == 1) check("ws_beat_data", data_out_b, 8'h7E);
      @(negedge clk);
      check("ws_after_rdy", rdy_b, 0);
      check("ws_after_gnt", gnt_b, 1);
    end
    req_b = 1'b0;
    @(negedge clk);
    check("ws_release_gnt", gnt_b, 0);

    // Random transactions against the reference model
    for (int n = 0; n < 60; n++) begin
      m    = 2'($urandom_range(0, 3));
      a    = 8'($urandom_range(0, 19));
      wd   = $urandom;
      e    = (a >= 8'd16);
      drop = ($urandom_range(0, 5) == 0);
      txn(m, a, wd, model_read(a), e, drop);
      model_apply(m, a, wd);
      if (drop) regrant();
    end

    // Asynchronous reset in the middle of a burst write
    start = 1'b1; mode = 2'b11; addr = 8'h08;
    @(negedge clk);
    start = 1'b0;
    check("rb_beat0_rdy", rdy, 1);
    data_in = 8'h5A;
    @(negedge clk);
    check("rb_beat1_rdy", rdy, 1);
    data_in = 8'h6B;
    @(negedge clk);
    check("rb_beat2_rdy", rdy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rb_async_rdy", rdy, 0);
    check("rb_async_gnt", gnt, 0);
    check("rb_async_err", err, 0);
    check("rb_async_oe", data_oe, 0);
    check("rb_async_dout", data_out, 8'h00);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    check("rb_idle_gnt", gnt, 0);
    regrant();
    for (int i = 0; i < 16; i++) txn(2'b00, 8'(i), 32'h0, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
